inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Fetch stage directly upstream of the instruction memory. Holds the PC and
//  drives the memory read port (addr/rd). Captures the 1-cycle-latency read
//  data and hands instr+pc to decode over a valid/ready handshake.
//  Supports a branch/jump redirect and a halt. Memory write port is tied off at top.
// PARAMETERS
//  WIDTH     32  instruction width; equals the memory data width
//  DEPTH     16  PC / word-address width; PC counts words (+1 per instr)
//  RESET_PC  0   PC value loaded on reset (DEPTH bits)
// PORTS
//  clk             in   1      clock, all state on posedge
//  rst             in   1      synchronous active-high reset
//  imem_addr       out  DEPTH  memory word address; combinational = pc
//  imem_rd         out  1      memory read enable; combinational issue signal
//  imem_data       in   WIDTH  memory read data, valid the cycle after imem_rd
//  halt            in   1      1 = issue no new reads; buffered instrs still drain
//  redirect_valid  in   1      1 = flush and restart fetch at redirect_pc
//  redirect_pc     in   DEPTH  redirect target word address
//  if_valid        out  1      if_instr/if_pc valid toward decode
//  if_instr        out  WIDTH  fetched instruction
//  if_pc           out  DEPTH  word address of if_instr
//  if_ready        in   1      decode accepts; transfer = if_valid & if_ready
// BEHAVIOUR
//  - Reset values: pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, skid empty.
//    pend=0. imem_rd is forced 0 while rst=1.
//  - State: pc, pend (read issued last cycle), out reg (if_*), 1-entry skid reg.
//  - occ = if_valid + skid_v + pend. cons = if_valid & if_ready.
//  - Issue: imem_rd = !rst & !halt & !redirect_valid & (occ - cons < 2).
//    When imem_rd=1, the tag pc is recorded with pend, and pc <= pc+1 (mod 2^DEPTH).
//    Example: 0xFFFF -> 0x0000.
//  - Return: while pend=1, imem_data is captured at this edge.
//    Destination is out reg if out is empty or being consumed and skid is empty.
//    Otherwise the data goes to skid.
//  - On cons with skid_v=1: skid -> out reg. Skid refills from pend in the same edge.
//  - Order preserved; no instruction dropped or duplicated under any ready pattern.
//  - Latency: read issued cycle N -> if_valid at N+2. Throughput 1 instr/cycle at if_ready=1.
//  - if_valid & !if_ready: if_instr/if_pc held stable until transfer.
//  - Redirect in cycle N (priority over halt and issue):
//    - imem_rd=0 in cycle N; pc <= redirect_pc.
//    - if_valid, skid_v and pend are cleared. A transfer in cycle N still counts as accepted.
//    - First read from redirect_pc issues at N+1; if_valid with if_pc=redirect_pc at N+3.
//  - Halt: no issue while halt=1. pend data and the buffer drain normally.
//    Deasserting halt resumes at the current pc.
//  - Reset mid-operation discards all in-flight data; data returning after reset is ignored.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//    - Adds port stall_cnt out 32.
//    - Increments each cycle with if_valid & !if_ready; saturates at 0xFFFF_FFFF.
//    - Reset to 0; a redirect does not clear it.
//  Not defined: port and counter are absent; all other behaviour is identical.
// TESTING
//  1 Mem[k]=0x1000_0000+k, if_ready=1, release rst at cycle 0:
//    -> if_valid from cycle 2; if_pc 0,1,2,... one per cycle; if_instr matches.
//  2 Drop if_ready for 3 cycles while if_pc=3:
//    -> if_pc/if_instr held at 3; imem_rd low once occ=2.
//    -> after release: 3,4,5,6 back-to-back, no gap/dup.
//  3 redirect_valid=1, redirect_pc=0x0040 with a read pending:
//    -> no old-stream instr after cycle N.
//    -> if_valid with if_pc=0x0040 at N+3, then 0x0041.
//  4 RESET_PC=0xFFFE -> if_pc sequence 0xFFFE, 0xFFFF, 0x0000.
//  5 halt=1 for 4 cycles with if_ready=1:
//    -> imem_rd=0; buffered instrs drain; if_valid=0.
//    -> after halt=0, fetch resumes at next pc with no skip.
//  6 FETCH_PERF_CNT_EN, if_ready=0 for 5 cycles with if_valid=1:
//    -> stall_cnt=5. Then rst -> stall_cnt=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Fetch stage: PC, instruction-memory read port, 1-entry skid buffer and a valid/ready handoff to decode.
// Optional feature: define FETCH_PERF_CNT_EN to add the stall_cnt output counter.
module inst_fetch #(
  parameter int              WIDTH    = 32,
  parameter int              DEPTH    = 16,
  parameter logic [DEPTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [DEPTH-1:0] imem_addr,
  output logic             imem_rd,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             halt,
  input  logic             redirect_valid,
  input  logic [DEPTH-1:0] redirect_pc,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_instr,
  output logic [DEPTH-1:0] if_pc,
  input  logic             if_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  logic [DEPTH-1:0] pc;
  logic             pend;
  logic [DEPTH-1:0] pend_pc;
  logic             skid_v;
  logic [WIDTH-1:0] skid_instr;
  logic [DEPTH-1:0] skid_pc;

  logic       cons;
  logic [1:0] occ;
  logic [1:0] occ_after;
  logic       out_free;

  // A read is only issued if out reg + skid can absorb its data next cycle.
  always_comb begin
    cons      = if_valid & if_ready;
    occ       = {1'b0, if_valid} + {1'b0, skid_v} + {1'b0, pend};
    occ_after = occ - {1'b0, cons};
    out_free  = ~if_valid | if_ready;
    imem_rd   = ~rst & ~halt & ~redirect_valid & (occ_after < 2'd2);
    imem_addr = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      pend       <= 1'b0;
      pend_pc    <= '0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      skid_v     <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      pend     <= 1'b0;
      if_valid <= 1'b0;
      skid_v   <= 1'b0;
    end else begin
      pend    <= imem_rd;
      pend_pc <= pc;
      if (imem_rd) pc <= pc + 1'b1;

      if (out_free) begin
        // Skid holds the older instruction, so it always moves ahead of returning data.
        if (skid_v) begin
          if_valid <= 1'b1;
          if_instr <= skid_instr;
          if_pc    <= skid_pc;
          skid_v   <= pend;
          if (pend) begin
            skid_instr <= imem_data;
            skid_pc    <= pend_pc;
          end
        end else if (pend) begin
          if_valid <= 1'b1;
          if_instr <= imem_data;
          if_pc    <= pend_pc;
        end else begin
          if_valid <= 1'b0;
        end
      end else if (pend) begin
        skid_v     <= 1'b1;
        skid_instr <= imem_data;
        skid_pc    <= pend_pc;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (if_valid && !if_ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, wrap/perf sequences, randomized scoreboard run.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, halt, redirect_valid, if_ready;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [15:0] if_pc;

  logic        rst2;
  logic [15:0] imem_addr2;
  logic        imem_rd2;
  logic [31:0] imem_data2;
  logic        if_valid2;
  logic [31:0] if_instr2;
  logic [15:0] if_pc2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, stall_cnt2;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  inst_fetch #(.WIDTH(32), .DEPTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  inst_fetch #(.WIDTH(32), .DEPTH(16), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_rd(imem_rd2), .imem_data(imem_data2),
    .halt(1'b0), .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2), .if_ready(1'b1)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  function automatic logic [31:0] memWord(input logic [15:0] a);
    return 32'h1000_0000 + {16'h0000, a};
  endfunction

  // Instruction memories with one cycle of read latency
  initial imem_data = '0;
  initial imem_data2 = '0;
  always @(posedge clk) if (imem_rd) imem_data <= memWord(imem_addr);
  always @(posedge clk) if (imem_rd2) imem_data2 <= memWord(imem_addr2);

  typedef struct {
    logic        rst, halt, rdv;
    logic [15:0] rdpc;
    logic        ready;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[27];

  task automatic applyStimulus(input logic r, input logic h, input logic rv,
                               input logic [15:0] rp, input logic rdy);
    @(negedge clk);
    rst = r; halt = h; redirect_valid = rv; redirect_pc = rp; if_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  initial begin
    logic [15:0] exp_next, fetch_ptr, prev_pc;
    logic [31:0] prev_instr;
    logic        prev_hold;
    logic        r, h, rv, rdy;
    logic [15:0] rp;

    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state
    applyStimulus(1, 0, 0, 16'h0, 1);
    checkOutput("reset if_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("reset if_pc", {16'h0, if_pc}, 32'd0);
    checkOutput("reset if_instr", if_instr, 32'd0);
    checkOutput("reset imem_rd", {31'b0, imem_rd}, 32'd0);

    // Streaming, backpressure, halt, redirect and mid-stream reset
    vecs[0]  = '{0,0,0,16'h0,1, 1,16'h0000, 0,16'h0000};
    vecs[1]  = '{0,0,0,16'h0,1, 1,16'h0001, 0,16'h0000};
    vecs[2]  = '{0,0,0,16'h0,1, 1,16'h0002, 1,16'h0000};
    vecs[3]  = '{0,0,0,16'h0,1, 1,16'h0003, 1,16'h0001};
    vecs[4]  = '{0,0,0,16'h0,1, 1,16'h0004, 1,16'h0002};
    vecs[5]  = '{0,0,0,16'h0,0, 0,16'h0000, 1,16'h0003};
    vecs[6]  = '{0,0,0,16'h0,0, 0,16'h0000, 1,16'h0003};
    vecs[7]  = '{0,0,0,16'h0,0, 0,16'h0000, 1,16'h0003};
    vecs[8]  = '{0,0,0,16'h0,1, 1,16'h0005, 1,16'h0003};
    vecs[9]  = '{0,0,0,16'h0,1, 1,16'h0006, 1,16'h0004};
    vecs[10] = '{0,0,0,16'h0,1, 1,16'h0007, 1,16'h0005};
    vecs[11] = '{0,1,0,16'h0,1, 0,16'h0000, 1,16'h0006};
    vecs[12] = '{0,1,0,16'h0,1, 0,16'h0000, 1,16'h0007};
    vecs[13] = '{0,1,0,16'h0,1, 0,16'h0000, 0,16'h0000};
    vecs[14] = '{0,1,0,16'h0,1, 0,16'h0000, 0,16'h0000};
    vecs[15] = '{0,0,0,16'h0,1, 1,16'h0008, 0,16'h0000};
    vecs[16] = '{0,0,0,16'h0,1, 1,16'h0009, 0,16'h0000};
    vecs[17] = '{0,0,0,16'h0,1, 1,16'h000A, 1,16'h0008};
    vecs[18] = '{0,0,1,16'h0040,1, 0,16'h0000, 1,16'h0009};
    vecs[19] = '{0,0,0,16'h0,1, 1,16'h0040, 0,16'h0000};
    vecs[20] = '{0,0,0,16'h0,1, 1,16'h0041, 0,16'h0000};
    vecs[21] = '{0,0,0,16'h0,1, 1,16'h0042, 1,16'h0040};
    vecs[22] = '{0,0,0,16'h0,1, 1,16'h0043, 1,16'h0041};
    vecs[23] = '{1,0,0,16'h0,1, 0,16'h0000, 1,16'h0042};
    vecs[24] = '{0,0,0,16'h0,1, 1,16'h0000, 0,16'h0000};
    vecs[25] = '{0,0,0,16'h0,1, 1,16'h0001, 0,16'h0000};
    vecs[26] = '{0,0,0,16'h0,1, 1,16'h0002, 1,16'h0000};

    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].halt, vecs[i].rdv, vecs[i].rdpc, vecs[i].ready);
      checkOutput($sformatf("vec%0d imem_rd", i), {31'b0, imem_rd}, {31'b0, vecs[i].exp_rd});
      if (vecs[i].exp_rd)
        checkOutput($sformatf("vec%0d imem_addr", i), {16'h0, imem_addr}, {16'h0, vecs[i].exp_addr});
      checkOutput($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d if_pc", i), {16'h0, if_pc}, {16'h0, vecs[i].exp_pc});
        checkOutput($sformatf("vec%0d if_instr", i), if_instr, memWord(vecs[i].exp_pc));
      end
    end

    // PC wrap from RESET_PC = 0xFFFE
    applyStimulus(1, 0, 0, 16'h0, 1);
    rst2 = 1'b0;
    applyStimulus(1, 0, 0, 16'h0, 1);
    applyStimulus(1, 0, 0, 16'h0, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("wrap%0d if_valid", k), {31'b0, if_valid2}, 32'd1);
      checkOutput($sformatf("wrap%0d if_pc", k), {16'h0, if_pc2}, {16'h0, 16'hFFFE + k[15:0]});
      checkOutput($sformatf("wrap%0d if_instr", k), if_instr2, memWord(16'hFFFE + k[15:0]));
      applyStimulus(1, 0, 0, 16'h0, 1);
    end

`ifdef FETCH_PERF_CNT_EN
    // Stall counter: 5 stalled cycles, then reset clears it
    checkOutput("stall_cnt reset", stall_cnt, 32'd0);
    applyStimulus(0, 0, 0, 16'h0, 1);
    applyStimulus(0, 0, 0, 16'h0, 1);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 16'h0, 0);
    applyStimulus(0, 0, 0, 16'h0, 1);
    checkOutput("stall_cnt after 5", stall_cnt, 32'd5);
    applyStimulus(1, 0, 0, 16'h0, 1);
    applyStimulus(1, 0, 0, 16'h0, 1);
    checkOutput("stall_cnt cleared", stall_cnt, 32'd0);
`endif

    // Randomized run against an in-order stream scoreboard
    applyStimulus(1, 0, 0, 16'h0, 1);
    exp_next  = 16'h0000;
    fetch_ptr = 16'h0000;
    prev_hold = 1'b0;
    prev_pc   = '0;
    prev_instr = '0;
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      h   = ($urandom_range(0, 9) == 0);
      rv  = ($urandom_range(0, 29) == 0);
      rp  = 16'($urandom_range(0, 65535));
      rdy = ($urandom_range(0, 9) < 7);
      applyStimulus(r, h, rv, rp, rdy);

      if (prev_hold) begin
        checkOutput("hold if_valid", {31'b0, if_valid}, 32'd1);
        checkOutput("hold if_pc", {16'h0, if_pc}, {16'h0, prev_pc});
        checkOutput("hold if_instr", if_instr, prev_instr);
      end
      if (r || h || rv) checkOutput("no issue when blocked", {31'b0, imem_rd}, 32'd0);
      if (imem_rd) checkOutput("fetch address", {16'h0, imem_addr}, {16'h0, fetch_ptr});
      if (!r && if_valid && if_ready) begin
        checkOutput("stream pc", {16'h0, if_pc}, {16'h0, exp_next});
        checkOutput("stream instr", if_instr, memWord(if_pc));
        exp_next = exp_next + 16'd1;
      end

      prev_hold  = !r && !rv && if_valid && !if_ready;
      prev_pc    = if_pc;
      prev_instr = if_instr;
      if (r) begin
        exp_next = 16'h0000; fetch_ptr = 16'h0000;
      end else if (rv) begin
        exp_next = rp; fetch_ptr = rp;
      end else if (imem_rd) begin
        fetch_ptr = fetch_ptr + 16'd1;
      end
    end

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
